// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: default PC unit constants and next-PC source indices
package pc_unit_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0000;
  localparam int DEF_EPC_OFFSET = 4;
  localparam int PC_SRC_ALU = 0;
  localparam int PC_SRC_ALUOUT = 1;
  localparam int PC_SRC_JUMP = 2;
  localparam int PC_SRC_EPC = 3;
endpackage

// File: rtl/pc_src_mux.sv
// pc_src_mux: combinational NUM_SRC-way next-PC selector with in-range flag
module pc_src_mux #(
  parameter int WIDTH = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W = $clog2(NUM_SRC)
) (
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_SRC*WIDTH-1:0] data,
  output logic [WIDTH-1:0]         target,
  output logic                     valid
);
  assign valid = 32'(sel) < 32'(NUM_SRC);
  // pick the addressed source; out-of-range selects yield zero and valid=0
  always_comb begin
    target = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sel == SEL_W'(i)) target = data[i*WIDTH +: WIDTH];
  end
endmodule

// File: rtl/pc_next_unit.sv
// pc_next_unit: PC/EPC registers with prioritised exception, return and checked loads
module pc_next_unit import pc_unit_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_SRC = 4,
  parameter int SEL_W = $clog2(NUM_SRC),
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter int EPC_OFFSET = DEF_EPC_OFFSET,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         src_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     pc_write,
  input  logic                     pc_write_cond,
  input  logic                     cond_taken,
  input  logic                     exc_req,
  input  logic                     eret,
  output logic [WIDTH-1:0]         pc,
  output logic [WIDTH-1:0]         epc,
  output logic                     pc_loaded,
  output logic                     addr_err,
  output logic                     sel_err
);
  logic [WIDTH-1:0] target;
  logic target_ok;
  logic load_req;
  logic misaligned;
  pc_src_mux #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W)) u_mux (
    .sel(src_sel),
    .data(src_data),
    .target(target),
    .valid(target_ok)
  );
  assign load_req = pc_write | (pc_write_cond & cond_taken);
  assign misaligned = ALIGN_CHECK && (target[1:0] != 2'b00);
  // exception entry beats return beats load; rejected loads hold pc and pulse an error
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      epc <= '0;
      pc_loaded <= 1'b0;
      addr_err <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      pc_loaded <= 1'b0;
      addr_err <= 1'b0;
      sel_err <= 1'b0;
      if (exc_req) begin
        epc <= pc - WIDTH'(EPC_OFFSET);
        pc <= EXC_VECTOR;
        pc_loaded <= 1'b1;
      end else if (eret) begin
        pc <= epc;
        pc_loaded <= 1'b1;
      end else if (load_req) begin
        if (!target_ok) sel_err <= 1'b1;
        else if (misaligned) addr_err <= 1'b1;
        else begin
          pc <= target;
          pc_loaded <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed vectors with a queued scoreboard checked by a monitor
module tb_pc_next_unit;
  import pc_unit_pkg::*;
  typedef struct {
    bit dut;
    string name;
    logic [31:0] pc;
    logic [31:0] epc;
    logic ld;
    logic ae;
    logic se;
  } exp_t;
  logic clk = 1'b0;
  logic reset, pc_write, pc_write_cond, cond_taken, exc_req, eret;
  logic [1:0] src_sel;
  logic [31:0] src [4];
  logic [127:0] src_data;
  logic [31:0] a_pc, a_epc, b_pc, b_epc;
  logic a_ld, a_ae, a_se, b_ld, b_ae, b_se;
  exp_t q[$];
  int checks = 0;
  int failures = 0;
  assign src_data = {src[3], src[2], src[1], src[0]};
  always #5 clk = ~clk;
  pc_next_unit #(.NUM_SRC(4), .EXC_VECTOR(32'h0000_0180)) dut_a (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_taken(cond_taken),
    .exc_req(exc_req), .eret(eret), .pc(a_pc), .epc(a_epc),
    .pc_loaded(a_ld), .addr_err(a_ae), .sel_err(a_se)
  );
  pc_next_unit #(.NUM_SRC(3)) dut_b (
    .clk(clk), .reset(reset), .src_sel(src_sel), .src_data(src_data[95:0]),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .cond_taken(cond_taken),
    .exc_req(exc_req), .eret(eret), .pc(b_pc), .epc(b_epc),
    .pc_loaded(b_ld), .addr_err(b_ae), .sel_err(b_se)
  );
  task automatic step(input bit d, input string nm, input logic rst, input int sel,
                      input logic [31:0] tgt, input logic pw, input logic pwc, input logic ct,
                      input logic ex, input logic er, input logic [31:0] e_pc,
                      input logic [31:0] e_epc, input logic e_ld, input logic e_ae, input logic e_se);
    exp_t e;
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) src[i] = 32'h0BAD_0000 + 32'(i * 16);
    src[sel] = tgt;
    src_sel = 2'(sel);
    reset = rst;
    pc_write = pw;
    pc_write_cond = pwc;
    cond_taken = ct;
    exc_req = ex;
    eret = er;
    e.dut = d; e.name = nm; e.pc = e_pc; e.epc = e_epc; e.ld = e_ld; e.ae = e_ae; e.se = e_se;
    q.push_back(e);
  endtask
  // after each edge, pop one expectation and compare it with the addressed instance
  initial begin
    exp_t e;
    logic [66:0] got, want;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        got = e.dut ? {b_pc, b_epc, b_ld, b_ae, b_se} : {a_pc, a_epc, a_ld, a_ae, a_se};
        want = {e.pc, e.epc, e.ld, e.ae, e.se};
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s: got pc=%h epc=%h ld=%b ae=%b se=%b, want pc=%h epc=%h ld=%b ae=%b se=%b",
                   e.name, got[66:35], got[34:3], got[2], got[1], got[0],
                   want[66:35], want[34:3], want[2], want[1], want[0]);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {reset, pc_write, pc_write_cond, cond_taken, exc_req, eret} = 6'b100000;
    src_sel = 2'd0;
    for (int i = 0; i < 4; i++) src[i] = '0;
    step(0, "reset1",      1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(0, "reset2",      1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(0, "idle_hold",   0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(0, "uncond_load", 0, PC_SRC_ALUOUT, 32'h40, 1, 0, 0, 0, 0, 32'h40, 32'h0, 1, 0, 0);
    step(0, "pulse_drop",  0, PC_SRC_ALUOUT, 32'h40, 0, 0, 0, 0, 0, 32'h40, 32'h0, 0, 0, 0);
    step(0, "br_not_tkn",  0, PC_SRC_ALUOUT, 32'h80, 0, 1, 0, 0, 0, 32'h40, 32'h0, 0, 0, 0);
    step(0, "br_taken",    0, PC_SRC_ALUOUT, 32'h80, 0, 1, 1, 0, 0, 32'h80, 32'h0, 1, 0, 0);
    step(0, "pw_and_pwc",  0, PC_SRC_JUMP, 32'h100, 1, 1, 0, 0, 0, 32'h100, 32'h0, 1, 0, 0);
    step(0, "exc_prio",    0, PC_SRC_ALU, 32'h200, 1, 0, 0, 1, 1, 32'h180, 32'hFC, 1, 0, 0);
    step(0, "eret_prio",   0, PC_SRC_ALU, 32'h204, 1, 0, 0, 0, 1, 32'hFC, 32'hFC, 1, 0, 0);
    step(0, "misaligned",  0, PC_SRC_ALU, 32'h102, 1, 0, 0, 0, 0, 32'hFC, 32'hFC, 0, 1, 0);
    step(0, "ae_drop",     0, PC_SRC_ALU, 32'h102, 0, 0, 0, 0, 0, 32'hFC, 32'hFC, 0, 0, 0);
    step(0, "exc2",        0, PC_SRC_ALU, 32'h0, 0, 0, 0, 1, 1, 32'h180, 32'hF8, 1, 0, 0);
    step(0, "load_src3",   0, PC_SRC_EPC, 32'h0, 1, 0, 0, 0, 0, 32'h0, 32'hF8, 1, 0, 0);
    step(0, "epc_wrap",    0, PC_SRC_ALU, 32'h0, 0, 0, 0, 1, 0, 32'h180, 32'hFFFF_FFFC, 1, 0, 0);
    step(0, "eret_vs_bad", 0, PC_SRC_ALU, 32'h3, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
    step(0, "reset_exc",   1, PC_SRC_ALU, 32'h0, 0, 0, 0, 1, 0, 32'h0, 32'h0, 0, 0, 0);
    step(0, "b2b_1",       0, PC_SRC_JUMP, 32'h10, 1, 0, 0, 0, 0, 32'h10, 32'h0, 1, 0, 0);
    step(0, "b2b_2",       0, PC_SRC_ALUOUT, 32'h20, 1, 0, 0, 0, 0, 32'h20, 32'h0, 1, 0, 0);
    step(0, "br_misalign", 0, PC_SRC_ALUOUT, 32'h21, 0, 1, 1, 0, 0, 32'h20, 32'h0, 0, 1, 0);
    step(1, "b_reset",     1, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0);
    step(1, "b_sel_oob",   0, 3, 32'h40, 1, 0, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1);
    step(1, "b_load_src2", 0, 2, 32'h44, 1, 0, 0, 0, 0, 32'h44, 32'h0, 1, 0, 0);
    step(1, "b_br_oob",    0, 3, 32'h0, 0, 1, 1, 0, 0, 32'h44, 32'h0, 0, 0, 1);
    step(1, "b_exc_oob",   0, 3, 32'h0, 1, 0, 0, 1, 0, 32'h0, 32'h40, 1, 0, 0);
    step(1, "b_idle",      0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h40, 0, 0, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
